lr_traffic_model: RTL

Local-road traffic model sitting on the sensor side of the traffic light controller. It queues arriving cars and produces the controller's `lr_has_car` input. It consumes the controller's `hw_light`/`lr_light` outputs and releases queued cars only while the local-road light is green, paced by a start-up delay and a per-car gap. It is used as a closed-loop stimulus/monitor for the controller in simulation and on the FPGA demo board.

---
 rtl/lr_traffic_model_if.sv | 36 +++
 rtl/lr_traffic_model.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lr_traffic_model_if.sv
// Sensor-side bundle between the traffic light controller and the local-road model.
// Lights come in from the controller; queue status and events go out.
interface lr_traffic_model_if #(
    parameter int CNT_W = 4
);
    logic             car_arrive;
    logic [2:0]       hw_light;
    logic [2:0]       lr_light;
    logic             lr_has_car;
    logic [CNT_W-1:0] queue_count;
    logic             car_depart;
    logic             overflow;
    logic             light_err;

    modport master (
        output car_arrive,
        output hw_light,
        output lr_light,
        input  lr_has_car,
        input  queue_count,
        input  car_depart,
        input  overflow,
        input  light_err
    );

    modport slave (
        input  car_arrive,
        input  hw_light,
        input  lr_light,
        output lr_has_car,
        output queue_count,
        output car_depart,
        output overflow,
        output light_err
    );
endinterface

// File: rtl/lr_traffic_model.sv
// Local-road car queue: releases cars on lr green after a start-up delay, one per gap.
// Optional light-conflict checker enabled by defining LR_SAFETY_CHECK_EN.
module lr_traffic_model #(
    parameter int DEPTH       = 15,
    parameter int CNT_W       = 4,
    parameter int START_DELAY = 2,
    parameter int DEPART_GAP  = 3
) (
    input logic               clk,
    input logic               rst,
    lr_traffic_model_if.slave bus
);
    localparam int TMR_MAX = (START_DELAY > DEPART_GAP) ? START_DELAY : DEPART_GAP;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_DELAY - 1);
    localparam logic [TMR_W-1:0] GAP_RELOAD = TMR_W'(DEPART_GAP - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [2:0] LIGHT_GREEN  = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b001;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_START,
        ST_FLOW
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             car_depart_q, car_depart_d;
    logic             overflow_q, overflow_d;

    logic lr_green;
    logic depart;
    logic full;
    logic accept;
    logic drop;

    assign lr_green = (bus.lr_light == LIGHT_GREEN);

    // Any non-green sample drops back to STOP so the next green pays the full delay.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        depart  = 1'b0;
        if (!lr_green) begin
            state_d = ST_STOP;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                ST_STOP: begin
                    state_d = ST_START;
                    tmr_d   = '0;
                end
                ST_START: begin
                    if (tmr_q == START_LAST) begin
                        state_d = ST_FLOW;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_ONE;
                    end
                end
                ST_FLOW: begin
                    if (tmr_q != '0) begin
                        tmr_d = tmr_q - TMR_ONE;
                    end else if (cnt_q != '0) begin
                        depart = 1'b1;
                        tmr_d  = GAP_RELOAD;
                    end
                end
                default: begin
                    state_d = ST_STOP;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    // A departure frees a slot in the same edge, so a full queue still accepts.
    always_comb begin
        full   = (cnt_q == CNT_FULL);
        accept = bus.car_arrive && (!full || depart);
        drop   = bus.car_arrive && full && !depart;
        unique case ({accept, depart})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        car_depart_d = depart;
        overflow_d   = overflow_q | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_STOP;
            cnt_q        <= '0;
            tmr_q        <= '0;
            car_depart_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            car_depart_q <= car_depart_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef LR_SAFETY_CHECK_EN
    logic light_err_q, light_err_d;
    logic hw_legal;
    logic lr_legal;
    logic both_go;

    always_comb begin
        hw_legal = (bus.hw_light == LIGHT_GREEN) ||
                   (bus.hw_light == LIGHT_YELLOW) ||
                   (bus.hw_light == LIGHT_RED);
        lr_legal = (bus.lr_light == LIGHT_GREEN) ||
                   (bus.lr_light == LIGHT_YELLOW) ||
                   (bus.lr_light == LIGHT_RED);
        both_go  = (bus.hw_light != LIGHT_RED) &&
                   (bus.lr_light != LIGHT_RED);
        light_err_d = light_err_q | both_go | !hw_legal | !lr_legal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            light_err_q <= 1'b0;
        end else begin
            light_err_q <= light_err_d;
        end
    end

    assign bus.light_err = light_err_q;
`else
    assign bus.light_err = 1'b0;
`endif

    assign bus.lr_has_car  = (cnt_q != '0);
    assign bus.queue_count = cnt_q;
    assign bus.car_depart  = car_depart_q;
    assign bus.overflow    = overflow_q;
endmodule
